// File: rtl/card_dealer.sv
// card_dealer: deals up to three cards from a free-running 1..13 counter on a
// debounced push-button, and keeps the hand's baccarat score.
module card_dealer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       deal_n,
    input  logic       clear,
    output logic [3:0] card0,
    output logic [3:0] card1,
    output logic [3:0] card2,
    output logic [1:0] num_cards,
    output logic       hand_full,
    output logic       deal_pulse,
    output logic [3:0] score,
    output logic       o_dbg_state,
    output logic [3:0] o_dbg_card_ctr,
    output logic [7:0] o_dbg_lockout
);

    typedef enum logic {
        ST_READY   = 1'b0,
        ST_LOCKOUT = 1'b1
    } state_t;

    localparam logic [7:0] LP_LOCK_LOAD = 8'(DEBOUNCE_CYCLES);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_card_ctr;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [7:0]  r_lockout;
    logic [3:0]  r_card0;
    logic [3:0]  r_card1;
    logic [3:0]  r_card2;
    logic [1:0]  r_num;
    logic [3:0]  r_score;
    logic        r_pulse;

    logic        w_press;
    logic        w_full;
    logic        w_deal;
    logic        w_lock_dec;
    logic [3:0]  w_pip;
    logic [4:0]  w_sum;
    logic [3:0]  w_score_next;

    // Free-running card source; the press timing is what makes the deal random.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_card_ctr <= 4'd1;
        end else if (r_card_ctr >= 4'd13) begin
            r_card_ctr <= 4'd1;
        end else begin
            r_card_ctr <= r_card_ctr + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= deal_n;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_press = r_prev & ~r_sync2;
    assign w_full  = (r_num == 2'd3);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_READY:   if (w_deal) w_next_state = ST_LOCKOUT;
            ST_LOCKOUT: if (r_lockout <= 8'd1) w_next_state = ST_READY;
            default:    w_next_state = ST_READY;
        endcase
    end

    // A discarded press (full hand or clear) leaves the FSM in READY with no lockout.
    always_comb begin
        w_deal     = 1'b0;
        w_lock_dec = 1'b0;
        case (r_state)
            ST_READY:   w_deal     = w_press & ~w_full & ~clear;
            ST_LOCKOUT: w_lock_dec = (r_lockout != 8'd0);
            default:    w_deal     = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_lockout <= 8'd0;
        end else if (w_deal) begin
            r_lockout <= LP_LOCK_LOAD;
        end else if (w_lock_dec) begin
            r_lockout <= r_lockout - 8'd1;
        end
    end

    // Running sum mod 10 equals the full-hand sum mod 10, so one adder suffices.
    assign w_pip        = (r_card_ctr <= 4'd9) ? r_card_ctr : 4'd0;
    assign w_sum        = {1'b0, r_score} + {1'b0, w_pip};
    assign w_score_next = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_card0 <= 4'd0;
            r_card1 <= 4'd0;
            r_card2 <= 4'd0;
            r_num   <= 2'd0;
            r_score <= 4'd0;
            r_pulse <= 1'b0;
        end else if (clear) begin
            r_card0 <= 4'd0;
            r_card1 <= 4'd0;
            r_card2 <= 4'd0;
            r_num   <= 2'd0;
            r_score <= 4'd0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_deal;
            if (w_deal) begin
                case (r_num)
                    2'd0:    r_card0 <= r_card_ctr;
                    2'd1:    r_card1 <= r_card_ctr;
                    2'd2:    r_card2 <= r_card_ctr;
                    default: r_card2 <= r_card2;
                endcase
                r_num   <= r_num + 2'd1;
                r_score <= w_score_next;
            end
        end
    end

    // deal_pulse is the valid strobe for the card/score outputs; there is no ready.
    assign card0          = r_card0;
    assign card1          = r_card1;
    assign card2          = r_card2;
    assign num_cards      = r_num;
    assign hand_full      = w_full;
    assign deal_pulse     = r_pulse;
    assign score          = r_score;
    assign o_dbg_state    = r_state;
    assign o_dbg_card_ctr = r_card_ctr;
    assign o_dbg_lockout  = r_lockout;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: randomized and directed stimulus against a queue-based hand model;
// a monitor pops expected deals whenever deal_pulse is seen.
module tb_card_dealer;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       resetb;
    logic       deal_n;
    logic       clear;
    logic [3:0] card0;
    logic [3:0] card1;
    logic [3:0] card2;
    logic [1:0] num_cards;
    logic       hand_full;
    logic       deal_pulse;
    logic [3:0] score;
    logic       dbg_state;
    logic [3:0] dbg_ctr;
    logic [7:0] dbg_lock;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: edges since reset, deal_n sampled at each edge, cards held.
    int          m_k         = 0;
    bit          m_hist[$];
    int          m_held[$];
    int          m_last_deal = -1000;
    logic [17:0] exp_q[$];

    card_dealer #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk            (clk),
        .resetb         (resetb),
        .deal_n         (deal_n),
        .clear          (clear),
        .card0          (card0),
        .card1          (card1),
        .card2          (card2),
        .num_cards      (num_cards),
        .hand_full      (hand_full),
        .deal_pulse     (deal_pulse),
        .score          (score),
        .o_dbg_state    (dbg_state),
        .o_dbg_card_ctr (dbg_ctr),
        .o_dbg_lockout  (dbg_lock)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic bit sample(input int j);
        if (j < 1) return 1'b1;
        return m_hist[j-1];
    endfunction

    function automatic logic [17:0] pack_hold();
        int c[3];
        int sum;
        c   = '{0, 0, 0};
        sum = 0;
        foreach (m_held[i]) begin
            c[i] = m_held[i];
            sum += (m_held[i] <= 9) ? m_held[i] : 0;
        end
        return {4'(c[0]), 4'(c[1]), 4'(c[2]), 2'(m_held.size()), 4'(sum % 10)};
    endfunction

    // A press is seen at edge k when deal_n was 0 at edge k-2 and 1 at edge k-3;
    // the card dealt is the counter value shown before that edge.
    always @(posedge clk) begin : model
        int cval;
        bit press;
        bit ready;
        if (resetb) begin
            cval = (m_k % 13) + 1;
            m_k++;
            m_hist.push_back(deal_n);
            press = (sample(m_k - 2) == 1'b0) && (sample(m_k - 3) == 1'b1);
            ready = (m_k >= m_last_deal + DEB + 1);
            if (clear) begin
                m_held.delete();
            end else if (press && ready && m_held.size() < 3) begin
                m_held.push_back(cval);
                m_last_deal = m_k;
                exp_q.push_back(pack_hold());
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [17:0] e;
        if (resetb) begin
            chk("card_ctr", int'(dbg_ctr), (m_k % 13) + 1);
            chk("lockout_state", int'(dbg_state), (m_k < m_last_deal + DEB) ? 1 : 0);
            chk("hold", int'({card0, card1, card2, num_cards, score}), int'(pack_hold()));
            if (deal_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("deal_packet", int'({card0, card1, card2, num_cards, score}), int'(e));
                    chk("deal_full", int'(hand_full), (e[5:4] == 2'd3) ? 1 : 0);
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_pulse", 0, 1);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cards"}, int'({card0, card1, card2}), 0);
        chk({tag, "_num"}, int'(num_cards), 0);
        chk({tag, "_score"}, int'(score), 0);
        chk({tag, "_pulse"}, int'(deal_pulse), 0);
        chk({tag, "_full"}, int'(hand_full), 0);
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        m_k = 0;
        m_hist.delete();
        m_held.delete();
        m_last_deal = -1000;
        exp_q.delete();
    endtask

    task automatic press_now(input int hold);
        @(negedge clk);
        deal_n = 1'b0;
        repeat (hold) @(negedge clk);
        deal_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic deal_value(input int v);
        int tries;
        tries = 0;
        @(negedge clk);
        while (!((((m_k + 2) % 13) + 1 == v) && (m_k + 3 >= m_last_deal + DEB + 1)) && tries < 100) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 100) chk("deal_window_timeout", tries, 0);
        deal_n = 1'b0;
        repeat (4) @(negedge clk);
        deal_n = 1'b1;
    endtask

    initial begin
        resetb = 1'b0;
        deal_n = 1'b1;
        clear  = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        chk("reset_ctr", int'(dbg_ctr), 1);

        // Press lands before the first edge after release.
        @(negedge clk);
        resetb = 1'b1;
        deal_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("first_card0", int'(card0), 3);
        chk("first_num", int'(num_cards), 1);
        chk("first_score", int'(score), 3);
        chk("first_pulse", int'(deal_pulse), 1);
        @(posedge clk);
        #1;
        chk("first_pulse_drop", int'(deal_pulse), 0);
        repeat (25) @(negedge clk);
        chk("held_low_one_deal", int'(num_cards), 1);
        deal_n = 1'b1;

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_num", int'(num_cards), 0);

        deal_value(7);
        chk("score_7", int'(score), 7);
        deal_value(8);
        chk("score_7_8", int'(score), 5);
        deal_value(13);
        chk("score_7_8_k", int'(score), 5);
        chk("full_after_3", int'(hand_full), 1);

        repeat (20) @(negedge clk);
        press_now(4);
        chk("full_press_num", int'(num_cards), 3);
        chk("full_press_card0", int'(card0), 7);

        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        deal_value(5);
        repeat (20) @(negedge clk);
        deal_n = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_all_zero("clear_vs_press");
        repeat (2) @(negedge clk);
        deal_n = 1'b1;
        deal_value(4);
        chk("after_clear_card0", int'(card0), 4);
        chk("after_clear_num", int'(num_cards), 1);

        press_now(3);
        chk("lockout_ignored", int'(num_cards), 1);
        repeat (20) @(negedge clk);
        press_now(4);
        chk("after_lockout_num", int'(num_cards), 2);

        repeat (20) @(negedge clk);
        press_now(4);
        #2;
        do_reset();
        #1;
        check_all_zero("mid_lockout_reset");
        chk("mid_reset_state", int'(dbg_state), 0);
        chk("mid_reset_ctr", int'(dbg_ctr), 1);
        repeat (2) @(negedge clk);
        resetb = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) deal_n = ~deal_n;
            clear = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        deal_n = 1'b1;
        clear  = 1'b0;
        repeat (25) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, sets the lockout length in clocks after an accepted deal; legal range 1..255.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port resetb, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port deal_n, input, 1 bit: raw push-button, active-low, asynchronous to clk.
REQ-005 Port clear, input, 1 bit: synchronous, active-high hand clear.
REQ-006 Port card0, output, 4 bits: first dealt card; 0 = blank, 1..13 = A..K; drives card7seg.
REQ-007 Port card1, output, 4 bits: second dealt card, same encoding.
REQ-008 Port card2, output, 4 bits: third dealt card, same encoding.
REQ-009 Port num_cards, output, 2 bits: cards held, 0..3.
REQ-010 Port hand_full, output, 1 bit: high when num_cards = 3.
REQ-011 Port deal_pulse, output, 1 bit: one-cycle strobe, high in the cycle the new card first appears.
REQ-012 Port score, output, 4 bits: baccarat hand score, 0..9.

Function
REQ-013 Card counter, 4 bits, advances every clock 1->2->...->13->1; it never holds 0 or 14..15. After rising edge k following reset release (edge 1 = first), its value is (k mod 13)+1.
REQ-014 deal_n passes through a two-flop synchronizer (sync1 -> sync2); both flops reset to 1.
REQ-015 A press event is high combinationally in any cycle where the registered previous sync2 = 1 and the current sync2 = 0.
REQ-016 FSM states:
- READY: press event with hand_full = 0 and clear = 0 -> deal, load lockout counter with DEBOUNCE_CYCLES, go to LOCKOUT.
- LOCKOUT: lockout counter decrements each clock; press events are ignored; on reaching 0 -> READY.
REQ-017 A deal writes the card counter's current value into the lowest-index empty slot (card0, then card1, then card2) at the capture edge. At the same edge: num_cards increments, score updates and deal_pulse is registered high for exactly one cycle.
REQ-018 Pip value = card if card <= 9, else 0. score = (sum of pips of held cards) mod 10, registered, valid in the same cycle as the updated card registers.
REQ-019 Press with hand_full = 1: no slot is written, deal_pulse stays 0, num_cards is unchanged, and the FSM stays in READY.
REQ-020 clear = 1 at an edge: card0..2, num_cards, score = 0 and deal_pulse = 0. Clear takes priority over a simultaneous deal; that press is discarded.
REQ-021 clear does not affect the card counter, the synchronizer, the FSM state or the lockout counter.
REQ-022 Holding deal_n low yields one deal only; a further deal requires a release followed by a new press after the lockout ends.

Reset
REQ-023 With resetb = 0, the following are forced asynchronously:
- card counter = 1
- sync1 = sync2 = previous = 1
- FSM = READY, lockout counter = 0
- card0..2 = 0, num_cards = 0, hand_full = 0, deal_pulse = 0, score = 0
REQ-024 Reset asserted mid-lockout or mid-hand discards all state; after release the block behaves as it does from power-up.

Verification
REQ-025 Reset: assert resetb = 0 between edges -> all outputs 0 immediately, without waiting for a clock edge; counter = 1 after release.
REQ-026 Timing: deal_n falls before edge 1, DEBOUNCE_CYCLES = 16 -> card0 = 3, num_cards = 1, score = 3 and deal_pulse = 1 after edge 3; deal_pulse = 0 after edge 4.
REQ-027 Score arithmetic: deal cards 7, 8, then 13 -> score sequence 7, 5, 5; hand_full = 1 after the third deal.
REQ-028 Full and lockout:
- Press while full -> no output change, deal_pulse stays 0.
- Press inside the 16-cycle lockout -> ignored.
- Press after lockout on a non-full hand -> accepted.
REQ-029 Clear: assert clear in the same cycle as a press event -> all cards = 0, num_cards = 0, score = 0, deal_pulse = 0; the next valid press writes card0.
REQ-030 Wrap: observe the counter over 30 cycles -> the sequence 1..13 repeats with no 0, 14 or 15 values.
